pipe_stage_reg: RTL



---
 rtl/my_pkg.sv | 66 ++++++
 rtl/pipe_slot.sv | 37 +++
 rtl/pipe_stage_reg.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/my_pkg.sv
// rtl/my_pkg.sv - shared types and default widths for pipe_stage_reg users
package my_pkg;

  // Default bundle widths; the stage is usually sized from the structs below.
  localparam int PIPE_CTRL_W = 16;
  localparam int PIPE_DATA_W = 160;
  localparam int PIPE_CNT_W  = 32;

  // Occupancy of the skid-buffered stage: nothing, main only, main + skid.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  // Decode-to-execute control bundle. Every bit that causes a side effect
  // downstream is active-high so an all-zero bundle is a harmless bubble.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       branch;
    logic [3:0] alu_op;
    logic [4:0] rd;
    logic [2:0] funct3;
  } id_ex_ctrl_t;

  // Decode-to-execute data bundle.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [31:0] next_pc;
  } id_ex_data_t;

  localparam int ID_EX_CTRL_W = $bits(id_ex_ctrl_t);
  localparam int ID_EX_DATA_W = $bits(id_ex_data_t);

  // Next occupancy of the skid-buffered stage. push is only ever seen
  // outside FULL because in_ready is low there.
  function automatic pipe_state_t pipe_next_state(
    input pipe_state_t cur,
    input logic        push,
    input logic        pop,
    input logic        flush
  );
    pipe_state_t nxt;
    nxt = cur;
    if (flush) begin
      nxt = EMPTY;
    end else begin
      case (cur)
        EMPTY: if (push) nxt = MAIN;
        MAIN: begin
          if (push && !pop)      nxt = FULL;
          else if (!push && pop) nxt = EMPTY;
        end
        FULL:    if (pop) nxt = MAIN;
        default: nxt = EMPTY;
      endcase
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one control+data holding register with load and clears
module pipe_slot
  import my_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DATA_W = PIPE_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clr_valid,
  input  logic              clr_ctrl,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [DATA_W-1:0] d_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  // Load wins over the clears; data is only ever replaced by a load so it
  // keeps its last value across a clear (bubble keeps stale data, zero ctrl).
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= d_ctrl;
      data  <= d_data;
    end else begin
      if (clr_valid) valid <= 1'b0;
      if (clr_ctrl)  ctrl  <= '0;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - elastic pipeline stage register (PIPE_STAGE_SKID_EN selects skid buffer)
module pipe_stage_reg
  import my_pkg::*;
#(
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              push;
  logic              pop;
  logic              main_load;
  logic              main_clr;
  logic [CTRL_W-1:0] main_d_ctrl;
  logic [DATA_W-1:0] main_d_data;
  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CNT_W-1:0]  stall_q;

  // The main slot is always the head; outputs come straight from its flops.
  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk       (clk),
    .rst       (rst),
    .load      (main_load),
    .clr_valid (main_clr),
    .clr_ctrl  (main_clr),
    .d_ctrl    (main_d_ctrl),
    .d_data    (main_d_data),
    .valid     (main_valid),
    .ctrl      (main_ctrl),
    .data      (main_data)
  );

  assign out_valid = main_valid;
  assign out_ctrl  = main_ctrl;
  assign out_data  = main_data;
  assign pop       = main_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN

  pipe_state_t       state_q;
  pipe_state_t       state_d;
  logic              in_ready_q;
  logic              main_sel_skid;
  logic              skid_load;
  logic              skid_clr;
  logic              skid_valid;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;

  // Second slot absorbs the push that lands while out_ready has just dropped.
  pipe_slot #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (skid_load),
    .clr_valid (skid_clr),
    .clr_ctrl  (skid_clr),
    .d_ctrl    (in_ctrl),
    .d_data    (in_data),
    .valid     (skid_valid),
    .ctrl      (skid_ctrl),
    .data      (skid_data)
  );

  // in_ready only ever comes from a flop so downstream ready never reaches upstream.
  assign in_ready    = in_ready_q;
  assign push        = in_valid & in_ready_q;
  assign main_d_ctrl = main_sel_skid ? skid_ctrl : in_ctrl;
  assign main_d_data = main_sel_skid ? skid_data : in_data;
  assign state_d     = pipe_next_state(state_q, push, pop, flush);

  // Slot steering for each occupancy state; flush kills both slots and any push.
  always_comb begin
    main_load     = 1'b0;
    main_clr      = 1'b0;
    main_sel_skid = 1'b0;
    skid_load     = 1'b0;
    skid_clr      = 1'b0;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) main_load = 1'b1;
        end
        MAIN: begin
          if (push && pop)  main_load = 1'b1;
          else if (push)    skid_load = 1'b1;
          else if (pop)     main_clr  = 1'b1;
        end
        FULL: begin
          if (pop && skid_valid) begin
            main_load     = 1'b1;
            main_sel_skid = 1'b1;
            skid_clr      = 1'b1;
          end
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  // Occupancy state and the registered ready that mirrors "not FULL next cycle".
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

`else

  // Single entry: accept when empty or when the head leaves this cycle.
  assign in_ready    = ~main_valid | out_ready;
  assign push        = in_valid & in_ready;
  assign main_d_ctrl = in_ctrl;
  assign main_d_data = in_data;

  // A push replaces the head (with or without pop); pop alone leaves a bubble.
  always_comb begin
    main_load = 1'b0;
    main_clr  = 1'b0;
    if (flush) begin
      main_clr = 1'b1;
    end else if (push) begin
      main_load = 1'b1;
    end else if (pop) begin
      main_clr = 1'b1;
    end
  end

`endif

  // Saturating count of cycles the head was refused; flush freezes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (main_valid && !out_ready && !flush && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stall_q;

endmodule
